// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: word and RAM status, plus the arbiter's
// FSM state and grant-register encodings.
package cpu_types_pkg;

   localparam int WORD_W = 32;

   typedef logic [WORD_W-1:0] word_t;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

   // Memory arbiter FSM states
   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   // Request class currently owning the RAM
   typedef enum logic {
      GNT_INSTR = 1'b0,
      GNT_DATA  = 1'b1
   } gnt_class_t;

   typedef struct packed {
      gnt_class_t cls;
      logic       core;
   } grant_t;

   localparam grant_t GRANT_NONE = '{cls: GNT_INSTR, core: 1'b0};

   // Convert a 2-way one-hot winner into a core index (core 1 only when bit 1 alone is set)
   function automatic logic onehot_to_core(input logic [1:0] oh);
      return oh[1] & ~oh[0];
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Two-way round-robin selector. ptr_i names the core that wins when
// both request; the other core wins only when it requests alone.
module rr_pick (
   input  logic [1:0] req_i,
   input  logic       ptr_i,
   output logic [1:0] gnt_o
);

   // Pick the favoured core if it requests, otherwise the other one
   always_comb begin
      gnt_o = 2'b00;
      if (ptr_i == 1'b0) begin
         gnt_o = req_i[0] ? 2'b01 : {req_i[1], 1'b0};
      end else begin
         gnt_o = req_i[1] ? 2'b10 : {1'b0, req_i[0]};
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Two-core shared-RAM arbiter. Data requests beat instruction requests;
// each class has its own round-robin pointer that moves away from the
// core it last completed. The grantee's live inputs drive the RAM, and
// its wait bit drops combinationally in the ACCESS cycle.
module mem_arbiter
   import cpu_types_pkg::*;
#(
   parameter int CPUS = 2
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic [CPUS-1:0] iREN,
   input  logic [CPUS-1:0] dREN,
   input  logic [CPUS-1:0] dWEN,
   input  word_t           iaddr  [CPUS],
   input  word_t           daddr  [CPUS],
   input  word_t           dstore [CPUS],
   output logic [CPUS-1:0] iwait,
   output logic [CPUS-1:0] dwait,
   output word_t           iload  [CPUS],
   output word_t           dload  [CPUS],
   output logic            ramREN,
   output logic            ramWEN,
   output word_t           ramaddr,
   output word_t           ramstore,
   input  word_t           ramload,
   input  ramstate_t       ramstate
);

   arb_state_t      state_q, state_d;
   grant_t          grant_q, grant_d;
   logic            dptr_q, dptr_d;
   logic            iptr_q, iptr_d;
   logic [CPUS-1:0] dreq_s;
   logic [1:0]      dgnt_s, ignt_s;
   logic            live_s;
   logic            done_s;

   assign dreq_s = dREN | dWEN;

   rr_pick u_pick_data (
      .req_i (dreq_s),
      .ptr_i (dptr_q),
      .gnt_o (dgnt_s)
   );

   rr_pick u_pick_instr (
      .req_i (iREN),
      .ptr_i (iptr_q),
      .gnt_o (ignt_s)
   );

   // Is the grantee still requesting, and is its access completing now
   always_comb begin
      live_s = 1'b0;
      if (state_q == GRANT) begin
         if (grant_q.cls == GNT_DATA) begin
            live_s = dreq_s[grant_q.core];
         end else begin
            live_s = iREN[grant_q.core];
         end
      end else begin
         live_s = 1'b0;
      end
   end

   assign done_s = live_s && (ramstate == ACCESS);

   // FSM state, grant and round-robin pointer registers
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
         grant_q <= GRANT_NONE;
         dptr_q  <= 1'b0;
         iptr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         dptr_q  <= dptr_d;
         iptr_q  <= iptr_d;
      end
   end

   // Next state: arbitrate in IDLE, release on completion or withdrawal
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      dptr_d  = dptr_q;
      iptr_d  = iptr_q;
      case (state_q)
         IDLE: begin
            if (|dreq_s) begin
               state_d      = GRANT;
               grant_d.cls  = GNT_DATA;
               grant_d.core = onehot_to_core(dgnt_s);
            end else if (|iREN) begin
               state_d      = GRANT;
               grant_d.cls  = GNT_INSTR;
               grant_d.core = onehot_to_core(ignt_s);
            end else begin
               state_d = IDLE;
            end
         end
         GRANT: begin
            if (!live_s) begin
               state_d = IDLE;
            end else if (done_s) begin
               state_d = IDLE;
               if (grant_q.cls == GNT_DATA) begin
                  dptr_d = ~grant_q.core;
               end else begin
                  iptr_d = ~grant_q.core;
               end
            end else begin
               state_d = GRANT;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // RAM controls and wait bits from the grantee's live inputs
   always_comb begin
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = {WORD_W{1'b0}};
      ramstore = {WORD_W{1'b0}};
      iwait    = {CPUS{1'b1}};
      dwait    = {CPUS{1'b1}};
      if (state_q == GRANT) begin
         if (grant_q.cls == GNT_DATA) begin
            ramaddr              = daddr[grant_q.core];
            ramstore             = dstore[grant_q.core];
            ramWEN               = dWEN[grant_q.core];
            ramREN               = dREN[grant_q.core] & ~dWEN[grant_q.core];
            dwait[grant_q.core]  = ~done_s;
         end else begin
            ramaddr              = iaddr[grant_q.core];
            ramREN               = iREN[grant_q.core];
            iwait[grant_q.core]  = ~done_s;
         end
      end else begin
         ramREN = 1'b0;
         ramWEN = 1'b0;
      end
   end

   // Load data is broadcast to every core on every cycle
   always_comb begin
      for (int k = 0; k < CPUS; k++) begin
         iload[k] = ramload;
         dload[k] = ramload;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a
// behavioural owner/last-served model.
`timescale 1ns/1ps
module tb_mem_arbiter;
   import cpu_types_pkg::*;

   logic       CLK = 1'b0;
   logic       RST;
   logic [1:0] iREN, dREN, dWEN, iwait, dwait;
   word_t      iaddr [2], daddr [2], dstore [2], iload [2], dload [2];
   logic       ramREN, ramWEN;
   word_t      ramaddr, ramstore, ramload;
   ramstate_t  ramstate;

   int n_checks = 0;
   int n_fail   = 0;

   // behavioural model: who owns the RAM and who was served last per class
   bit m_busy = 1'b0;
   bit m_data = 1'b0;
   int m_core = 0;
   int last_d = 1;
   int last_i = 1;

   logic [1:0] e_iw, e_dw;
   logic       e_ren, e_wen;
   word_t      e_addr, e_store;
   bit         live, done;

   always #5 CLK = ~CLK;

   mem_arbiter #(.CPUS(2)) dut (
      .CLK(CLK), .RST(RST),
      .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
      .iaddr(iaddr), .daddr(daddr), .dstore(dstore),
      .iwait(iwait), .dwait(dwait),
      .iload(iload), .dload(dload),
      .ramREN(ramREN), .ramWEN(ramWEN),
      .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ramstate(ramstate)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // the core that did not go last wins if it requests, else the other
   function automatic int pick(input logic [1:0] req, input int last);
      int other;
      other = 1 - last;
      return req[other] ? other : last;
   endfunction

   // every-cycle comparison against the model, then advance the model
   always @(negedge CLK) begin
      e_iw = 2'b11; e_dw = 2'b11; e_ren = 1'b0; e_wen = 1'b0;
      e_addr = 32'h0; e_store = 32'h0; live = 1'b0; done = 1'b0;
      if (RST) begin
         m_busy = 1'b0; last_d = 1; last_i = 1;
      end else if (m_busy) begin
         if (m_data) begin
            live    = dREN[m_core] | dWEN[m_core];
            e_addr  = daddr[m_core];
            e_store = dstore[m_core];
            e_wen   = dWEN[m_core];
            e_ren   = dREN[m_core] && !dWEN[m_core];
         end else begin
            live   = iREN[m_core];
            e_addr = iaddr[m_core];
            e_ren  = iREN[m_core];
         end
         done = live && (ramstate == ACCESS);
         if (done) begin
            if (m_data) e_dw[m_core] = 1'b0;
            else        e_iw[m_core] = 1'b0;
         end
      end
      chk("ramREN", ramREN, e_ren);
      chk("ramWEN", ramWEN, e_wen);
      chk("ramaddr", ramaddr, e_addr);
      chk("ramstore", ramstore, e_store);
      chk("iwait", iwait, e_iw);
      chk("dwait", dwait, e_dw);
      chk("iload0", iload[0], ramload);
      chk("iload1", iload[1], ramload);
      chk("dload0", dload[0], ramload);
      chk("dload1", dload[1], ramload);
      if (!RST) begin
         if (!m_busy) begin
            if (|(dREN | dWEN)) begin
               m_busy = 1'b1; m_data = 1'b1; m_core = pick(dREN | dWEN, last_d);
            end else if (|iREN) begin
               m_busy = 1'b1; m_data = 1'b0; m_core = pick(iREN, last_i);
            end
         end else if (!live) begin
            m_busy = 1'b0;
         end else if (done) begin
            m_busy = 1'b0;
            if (m_data) last_d = m_core;
            else        last_i = m_core;
         end
      end
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic samp();
      @(negedge CLK);
   endtask

   initial begin
      RST = 1'b1; iREN = 2'b00; dREN = 2'b00; dWEN = 2'b00;
      ramstate = FREE; ramload = 32'h0;
      for (int k = 0; k < 2; k++) begin
         iaddr[k] = 32'h0; daddr[k] = 32'h0; dstore[k] = 32'h0;
      end

      // reset values
      samp();
      chk("rst_ren", ramREN, 1'b0);
      chk("rst_wen", ramWEN, 1'b0);
      chk("rst_addr", ramaddr, 32'h0);
      chk("rst_store", ramstore, 32'h0);
      chk("rst_iwait", iwait, 2'b11);
      chk("rst_dwait", dwait, 2'b11);

      // S1: core0 fetch, ACCESS two cycles after grant begins
      step(); RST = 1'b0; iREN = 2'b01; iaddr[0] = 32'h100;
      samp(); chk("s1_c0_ren", ramREN, 1'b0);
      step();
      samp(); chk("s1_c1_ren", ramREN, 1'b1); chk("s1_c1_addr", ramaddr, 32'h100);
      chk("s1_c1_iwait", iwait, 2'b11);
      step(); ramstate = BUSY;
      samp(); chk("s1_c2_iwait", iwait, 2'b11);
      step(); ramstate = ACCESS; ramload = 32'h12345678;
      samp(); chk("s1_c3_iwait", iwait, 2'b10); chk("s1_c3_iload", iload[0], 32'h12345678);
      step(); iREN = 2'b00; ramstate = FREE;
      samp(); chk("s1_c4_iwait", iwait, 2'b11); chk("s1_c4_ren", ramREN, 1'b0);

      // S2: core0 write beats core1 fetch; fetch after one idle cycle
      step(); dWEN = 2'b01; daddr[0] = 32'h200; dstore[0] = 32'hDEADBEEF;
      iREN = 2'b10; iaddr[1] = 32'h300;
      samp(); chk("s2_c0_wen", ramWEN, 1'b0);
      step(); ramstate = ACCESS;
      samp(); chk("s2_wen", ramWEN, 1'b1); chk("s2_ren", ramREN, 1'b0);
      chk("s2_store", ramstore, 32'hDEADBEEF); chk("s2_addr", ramaddr, 32'h200);
      chk("s2_dwait", dwait, 2'b10);
      step(); dWEN = 2'b00; ramstate = FREE;
      samp(); chk("s2_idle_ren", ramREN, 1'b0); chk("s2_idle_wen", ramWEN, 1'b0);
      step(); ramstate = ACCESS;
      samp(); chk("s2_f_ren", ramREN, 1'b1); chk("s2_f_addr", ramaddr, 32'h300);
      chk("s2_f_iwait", iwait, 2'b01);
      step(); iREN = 2'b00; ramstate = FREE;

      // S3: both cores read continuously, immediate ACCESS -> 0,1,0,1
      step(); RST = 1'b1;
      step(); RST = 1'b0; dREN = 2'b11; daddr[0] = 32'h10; daddr[1] = 32'h20; ramstate = ACCESS;
      for (int k = 1; k <= 8; k++) begin
         step(); samp();
         if (k % 2 == 1) begin
            chk("s3_addr", ramaddr, (((k - 1) / 2) % 2 == 0) ? 32'h10 : 32'h20);
            chk("s3_dwait", dwait, (((k - 1) / 2) % 2 == 0) ? 2'b10 : 2'b01);
         end else begin
            chk("s3_idle_ren", ramREN, 1'b0);
            chk("s3_idle_dwait", dwait, 2'b11);
         end
      end
      step(); dREN = 2'b00; ramstate = FREE;

      // S4: serve core0 (pointer -> core1), then core1 withdraws during BUSY
      step(); dREN = 2'b01; ramstate = ACCESS;
      step();
      step(); dREN = 2'b10; ramstate = BUSY;
      step(); samp(); chk("s4_ren", ramREN, 1'b1); chk("s4_addr", ramaddr, 32'h20);
      step(); dREN = 2'b00;
      samp(); chk("s4_wd_ren", ramREN, 1'b0); chk("s4_wd_dwait", dwait, 2'b11);
      step(); samp(); chk("s4_idle_ren", ramREN, 1'b0);
      dREN = 2'b11; ramstate = ACCESS;
      step(); samp(); chk("s4_ptr_addr", ramaddr, 32'h20); chk("s4_ptr_dwait", dwait, 2'b01);
      step(); dREN = 2'b00; ramstate = FREE;

      // S5: ERROR for three cycles, then ACCESS
      step(); iREN = 2'b01; iaddr[0] = 32'h100; ramstate = ERROR;
      for (int k = 0; k < 3; k++) begin
         step(); samp(); chk("s5_err_iwait", iwait, 2'b11); chk("s5_err_ren", ramREN, 1'b1);
      end
      step(); ramstate = ACCESS;
      samp(); chk("s5_acc_iwait", iwait, 2'b10);
      step(); iREN = 2'b00; ramstate = FREE;

      // S6: reset mid-grant drops everything at once; pointers return to core0
      step(); dREN = 2'b01; daddr[0] = 32'h10; ramstate = ACCESS;
      step();
      step(); ramstate = BUSY;
      step(); samp(); chk("s6_pre_ren", ramREN, 1'b1);
      #2 RST = 1'b1;
      #1;
      chk("s6_rst_ren", ramREN, 1'b0); chk("s6_rst_wen", ramWEN, 1'b0);
      chk("s6_rst_dwait", dwait, 2'b11); chk("s6_rst_iwait", iwait, 2'b11);
      chk("s6_rst_addr", ramaddr, 32'h0);
      step();
      step(); RST = 1'b0; dREN = 2'b11; ramstate = ACCESS;
      step(); samp(); chk("s6_ptr_addr", ramaddr, 32'h10); chk("s6_ptr_dwait", dwait, 2'b10);
      step(); dREN = 2'b00; ramstate = FREE;

      // randomized traffic with sticky requests and occasional resets
      for (int n = 0; n < 3000; n++) begin
         step();
         if ($urandom_range(0, 3) == 0) iREN = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0) dREN = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 4) == 0) dWEN = 2'($urandom_range(0, 3));
         for (int k = 0; k < 2; k++) begin
            iaddr[k] = $urandom; daddr[k] = $urandom; dstore[k] = $urandom;
         end
         ramstate = ramstate_t'($urandom_range(0, 3));
         ramload  = $urandom;
         RST      = ($urandom_range(0, 199) == 0);
      end
      step(); RST = 1'b0; iREN = 2'b00; dREN = 2'b00; dWEN = 2'b00; ramstate = FREE;
      step(); samp();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter CPUS, default 2, meaning the number of cores sharing RAM; only the value 2 is supported.
REQ-002 SHALL have port CLK  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port RST  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have ports iREN, dREN, dWEN  input  [CPUS]  per-core instruction read, data read and data write requests.
REQ-005 SHALL have ports iaddr, daddr, dstore  input  word_t[CPUS]  per-core instruction address, data address and store data.
REQ-006 SHALL have ports iwait, dwait  output  [CPUS]  per-core stall; low for exactly the completion cycle of that core's access.
REQ-007 SHALL have ports iload, dload  output  word_t[CPUS]  per-core load data, equal to ramload on every cycle.
REQ-008 SHALL have ports ramREN, ramWEN  output  1  RAM read and write enables.
REQ-009 SHALL have ports ramaddr, ramstore  output  word_t  RAM address and write data.
REQ-010 SHALL have port ramload  input  word_t  RAM read data.
REQ-011 SHALL have port ramstate  input  ramstate_t  RAM status, one of FREE, BUSY, ACCESS or ERROR.

Function
- REQ-012 SHALL implement a 2-state FSM.
  - IDLE: no grant held.
  - GRANT: one requester owns RAM.
- REQ-013 In IDLE, when any request is asserted, SHALL register a winner and move to GRANT on the next edge.
  - RAM enables assert one cycle after the request is first seen.
- REQ-014 Winner priority: any data request beats any instruction request.
  - Among data requests, choose by the data round-robin pointer.
  - Among instruction requests, choose by a separate instruction round-robin pointer.
- REQ-015 Each round-robin pointer SHALL point away from the core just served, updated on that class's completion only.
- REQ-016 In GRANT, SHALL drive ramaddr, ramstore, ramREN and ramWEN from the grantee's live inputs only; all RAM enables are low in IDLE.
- REQ-017 For a data grantee with dWEN=1, ramWEN=1 and ramREN=0, regardless of dREN (write wins).
- REQ-018 When ramstate==ACCESS in GRANT, SHALL drive the grantee's wait low that same cycle and return to IDLE.
  - This yields one idle cycle between consecutive grants.
- REQ-019 If the grantee drops its request during GRANT, SHALL return to IDLE next edge with no completion and no pointer update.
- REQ-020 On ramstate ERROR, FREE or BUSY in GRANT, SHALL hold the grant with wait high.
- REQ-021 Every wait bit SHALL be high except the grantee's in its completion cycle.
  - iwait/dwait for non-requesting cores are also high; consumers qualify with their own REN/WEN.
- REQ-022 When the same core raises iREN and dREN together, SHALL serve data first.
  - The instruction request waits and is granted after the next IDLE cycle.

Reset
REQ-023 On RST high, SHALL asynchronously go to IDLE, clear both pointers to core 0, and clear the grant register.
REQ-024 During reset, SHALL hold ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, and all iwait/dwait=1.
REQ-025 If RST asserts mid-GRANT, SHALL abandon the access with no completion pulse; requesters re-arbitrate after release.

Structure
REQ-026 word_t and ramstate_t SHALL come from cpu_types_pkg; grant encoding and FSM state typedefs SHALL be added to that package.
REQ-027 A sub-module rr_pick (2-way round-robin selector: request vector and pointer in, one-hot winner out) SHALL be instantiated twice, once for data and once for instructions.

Verification
REQ-028 Bench SHALL cover these directed scenarios:
- Reset, then core0 iREN with iaddr=0x100 and RAM ACCESS after 2 cycles -> ramREN high from cycle 1; iwait[0] low only in cycle 3; iload[0]=ramload.
- Core0 dWEN with daddr=0x200 and dstore=0xDEADBEEF, plus core1 iREN, same cycle -> write granted first with ramstore=0xDEADBEEF; core1 fetch granted after completion plus 1 idle cycle.
- Both cores dREN continuously with immediate ACCESS -> grants alternate 0,1,0,1; each dwait low pulse is 1 cycle.
- Core1 dREN withdrawn while ramstate=BUSY -> FSM reaches IDLE next edge, ramREN=0, no dwait pulse, data pointer unchanged.
- ramstate=ERROR for 3 cycles then ACCESS -> wait held high during ERROR; completes on the ACCESS cycle.
- RST asserted mid-GRANT -> ramREN/ramWEN drop immediately (asynchronous); all waits high; pointers reset to core 0.
